// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader
//  Purpose  : Byte-stream program loader sitting in front of the instruction
//             memory. It takes a length-prefixed, little-endian byte stream
//             over a valid/ready handshake, assembles 32-bit instructions and
//             writes them to consecutive word addresses. It holds the CPU in
//             reset (o_cpu_hold) until the load has completed. The enclosing
//             top level uses o_cpu_hold to steer the memory address port
//             between o_mem_address (hold=1) and the CPU PC (hold=0).
//
//  Stream   : count[7:0], count[15:8], then count words, each sent LSB first.
//
//  Option   : LOADER_CHECKSUM_EN - adds a trailing checksum byte (XOR of all
//             preceding bytes, length bytes included). A mismatch ends in
//             ERROR; the words already written stay in memory.
//
//  Ports    : clk              rising-edge clock
//             reset            asynchronous active-low reset
//             i_start          one-cycle pulse, re-arms from DONE or ERROR
//             i_s_data[7:0]    stream byte
//             i_s_valid        stream byte valid
//             o_s_ready        loader accepts a byte this cycle
//             o_mem_write_en   one-cycle instruction-memory write strobe
//             o_mem_address    byte address of the write
//             o_mem_write_inst assembled instruction
//             o_cpu_hold       1 = CPU held in reset, loader owns address port
//             o_done           level, load completed OK
//             o_error          level, load aborted
//
//  Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int          MEM_BYTES = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [7:0]  i_s_data,
    input  logic        i_s_valid,
    output logic        o_s_ready,
    output logic        o_mem_write_en,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_write_inst,
    output logic        o_cpu_hold,
    output logic        o_done,
    output logic        o_error
);

    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_WRITE  = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM   = 3'd4,
`endif
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    // Largest legal word count; one extra bit so MEM_BYTES=256K still fits.
    localparam logic [16:0] c_MAX_WORDS = 17'(MEM_BYTES / 4);

    // State entered once the last word (or an empty program) has been handled.
`ifdef LOADER_CHECKSUM_EN
    localparam state_t c_FINISH = S_CSUM;
`else
    localparam state_t c_FINISH = S_DONE;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_count;
    logic [15:0] r_word_idx;
    logic [1:0]  r_byte_idx;
    logic [31:0] r_inst;
    logic [31:0] r_addr;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    logic        w_ready;
    logic        w_xfer;
    logic [15:0] w_len;
    logic        w_last_word;

    always_comb begin
        w_ready = 1'b0;
        unique case (r_state)
            S_LEN_LO, S_LEN_HI, S_DATA: w_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM:                     w_ready = 1'b1;
`endif
            default:                    w_ready = 1'b0;
        endcase
    end

    assign w_xfer      = i_s_valid & w_ready;
    // Full length as it becomes known on the LEN_HI transfer.
    assign w_len       = {i_s_data, r_count[7:0]};
    assign w_last_word = ((r_word_idx + 16'd1) == r_count);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_LEN_LO: begin
                if (w_xfer) w_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_xfer) begin
                    if ({1'b0, w_len} > c_MAX_WORDS) w_next = S_ERROR;
                    else if (w_len == 16'd0)          w_next = c_FINISH;
                    else                              w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_xfer && (r_byte_idx == 2'd3)) w_next = S_WRITE;
            end
            S_WRITE: begin
                w_next = w_last_word ? c_FINISH : S_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (w_xfer) w_next = (i_s_data == r_csum) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE: begin
                if (i_start) w_next = S_LEN_LO;
            end
            S_ERROR: begin
                if (i_start) w_next = S_LEN_LO;
            end
            default: w_next = S_LEN_LO;
        endcase
    end

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_LEN_LO;
            r_count    <= 16'd0;
            r_word_idx <= 16'd0;
            r_byte_idx <= 2'd0;
            r_inst     <= 32'd0;
            r_addr     <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
            r_csum     <= 8'd0;
`endif
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_LEN_LO: begin
                    if (w_xfer) r_count[7:0] <= i_s_data;
                end
                S_LEN_HI: begin
                    if (w_xfer) begin
                        r_count[15:8] <= i_s_data;
                        r_byte_idx    <= 2'd0;
                        r_word_idx    <= 16'd0;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_inst[{r_byte_idx, 3'b000} +: 8] <= i_s_data;
                        // Wraps back to 0 after the 4th byte of a word.
                        r_byte_idx <= r_byte_idx + 2'd1;
                    end
                end
                S_WRITE: begin
                    r_word_idx <= r_word_idx + 16'd1;
                    r_addr     <= r_addr + 32'd4;
                end
                S_DONE, S_ERROR: begin
                    if (i_start) begin
                        r_count    <= 16'd0;
                        r_word_idx <= 16'd0;
                        r_byte_idx <= 2'd0;
                        r_addr     <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
                        r_csum     <= 8'd0;
`endif
                    end
                end
                default: ;
            endcase
`ifdef LOADER_CHECKSUM_EN
            // Running XOR over every byte except the checksum byte itself.
            if (w_xfer && (r_state != S_CSUM)) r_csum <= r_csum ^ i_s_data;
`endif
        end
    end

    assign o_s_ready        = w_ready;
    assign o_mem_write_en   = (r_state == S_WRITE);
    assign o_mem_address    = r_addr;
    assign o_mem_write_inst = r_inst;
    assign o_cpu_hold       = (r_state != S_DONE);
    assign o_done           = (r_state == S_DONE);
    assign o_error          = (r_state == S_ERROR);

endmodule
`default_nettype wire

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader upstream of the instruction memory.
- Receives a length-prefixed little-endian byte stream over a valid/ready handshake, assembles 32-bit instructions, and writes them to consecutive word addresses through the memory's write port.
- Holds the CPU in reset until the load completes.
- Top level muxes the memory address port between mem_address (cpu_hold=1) and the PC (cpu_hold=0).

Parameters:
- MEM_BYTES, 1024, instruction memory size in bytes; max words = MEM_BYTES/4.
- BASE_ADDR, 0, byte address of the first written word; must be 4-byte aligned.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; re-arms loader from DONE or ERROR.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts byte this cycle.
- mem_write_en  out  1  one-cycle write strobe to instruction memory.
- mem_address  out  32  byte address of the write.
- mem_write_inst  out  32  assembled instruction.
- cpu_hold  out  1  1 = hold CPU in reset and own the memory address port.
- done  out  1  level, load completed OK.
- error  out  1  level, load aborted.

Behaviour:
- Reset (reset=0, async) values:
  - state=LEN_LO, cpu_hold=1, s_ready=1.
  - mem_write_en=0, mem_address=BASE_ADDR, mem_write_inst=0.
  - done=0, error=0; internal counters cleared.
- Byte transfer occurs on a rising edge with s_valid & s_ready; no byte is lost or duplicated.
- Stream format: count[7:0], count[15:8], then count words, each sent LSB first (byte0 -> inst[7:0] ... byte3 -> inst[31:24]).
- States:
  - LEN_LO: s_ready=1; on transfer latch count low byte -> LEN_HI.
  - LEN_HI: s_ready=1; on transfer latch count high byte, then evaluate:
    - count > MEM_BYTES/4 -> ERROR.
    - count == 0 -> DONE (or CSUM, see Optional Feature).
    - otherwise -> DATA with byte_idx=0, word_idx=0.
  - DATA: s_ready=1; each transfer shifts the byte into the assembly register at byte_idx, then byte_idx++. On the 4th byte -> WRITE.
  - WRITE: s_ready=0; mem_write_en=1 for exactly one cycle, with mem_address=BASE_ADDR+4*word_idx and mem_write_inst=assembled word stable during that cycle. Next cycle:
    - word_idx++ and mem_address advances by 4.
    - word_idx+1 == count -> DONE (or CSUM); else -> DATA.
  - DONE: s_ready=0, done=1, cpu_hold=0; stays until start.
  - ERROR: s_ready=0, error=1, cpu_hold=1, no writes; stays until start.
- start in DONE or ERROR:
  - next state LEN_LO, cpu_hold=1, done=0, error=0.
  - mem_address=BASE_ADDR, counters cleared.
- start in any other state is ignored.
- Writes never exceed BASE_ADDR+4*(MEM_BYTES/4)-4; this is guaranteed by the count check.
- Reset mid-load: immediate return to reset values. A partially assembled word is discarded and never written. Previously written memory contents are untouched.
- mem_write_en is never asserted outside WRITE. Consecutive writes are separated by at least 4 accepted bytes.
- s_valid may drop between bytes at any position; assembly state is held.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- When defined:
  - After the last word (or directly after LEN_HI when count==0), state CSUM accepts one byte with s_ready=1.
  - Expected value = XOR of all preceding bytes including both length bytes.
  - Match -> DONE; mismatch -> ERROR.
  - Words already written remain in memory, but cpu_hold stays 1.
- When undefined: no CSUM state; the last write (or count==0) goes directly to DONE.

Test Plan:
- Stream 02 00 13 00 00 00 93 00 10 00, s_valid always 1 -> writes (0x000, 0x00000013) then (0x004, 0x00100093); done=1 and cpu_hold=0 two cycles after the last byte.
- Same stream with s_valid toggling every other cycle -> identical writes, exactly 2 mem_write_en pulses, s_ready=0 only in WRITE and DONE.
- Count 0x0101 (257 words) -> error=1, cpu_hold=1, zero mem_write_en pulses; then start -> LEN_LO, error=0.
- Count 0x0100 (256 words) of incrementing data -> last write at address 0x3FC, done=1.
- Assert reset after the 2nd data byte of word 1 -> no write for that word; all outputs return to reset values asynchronously; a fresh full stream then loads correctly from 0x000.
- LOADER_CHECKSUM_EN: stream 01 00 13 00 00 00 12 -> done=1. Same stream with trailing byte 00 -> error=1 and cpu_hold=1, though word 0x00000013 is written at 0x000.
